inst_cache: RTL

Direct-mapped, read-only instruction cache between the core's fetch port and the instruction memory. The core drives `inst_addr`. The block returns `inst` with `hit`. On a miss it fills a 4-word line from memory, one word per `MEM_LATENCY`-cycle access, while holding `hit` low. The core uses `~hit` as its fetch stall.

---
 rtl/inst_cache_if.sv | 34 +++
 rtl/inst_cache.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/inst_cache_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_cache_if
//  Purpose  : Bundles the fetch-side and memory-side signals of inst_cache.
//             master = core/memory environment, slave = the cache itself.
//  Signals  : inst_addr, invalidate  (core -> cache)
//             inst, hit, miss_count  (cache -> core)
//             mem_addr, mem_rd_en    (cache -> memory)
//             mem_inst               (memory -> cache)
//  Revision : 1.0 - initial release
// ============================================================================
interface inst_cache_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] inst_addr;
    logic            invalidate;
    logic [XLEN-1:0] inst;
    logic            hit;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rd_en;
    logic [XLEN-1:0] mem_inst;
    logic [15:0]     miss_count;

    modport master (
        output inst_addr, invalidate, mem_inst,
        input  inst, hit, mem_addr, mem_rd_en, miss_count
    );

    modport slave (
        input  inst_addr, invalidate, mem_inst,
        output inst, hit, mem_addr, mem_rd_en, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
//  Module   : inst_cache
//  Purpose  : Direct-mapped, read-only instruction cache with 4-word lines.
//             Hits are combinational; a miss fills the line from memory one
//             word per MEM_LATENCY cycles while hit is held low.
//  Ports    : clk, rst_b (async, active-low)
//             bus (inst_cache_if.slave): inst_addr, invalidate, inst, hit,
//             mem_addr, mem_rd_en, mem_inst, miss_count
//  Revision : 1.0 - initial release
// ============================================================================
module inst_cache #(
    parameter int XLEN        = 32,
    parameter int INDEX_BITS  = 6,
    parameter int MEM_LATENCY = 2
) (
    input wire          clk,
    input wire          rst_b,
    inst_cache_if.slave bus
);
    localparam int c_lines    = 1 << INDEX_BITS;
    localparam int c_tag_bits = XLEN - INDEX_BITS - 4;
    localparam int c_lat_w    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(MEM_LATENCY - 1);
    localparam logic [c_lat_w-1:0] c_lat_one  = c_lat_w'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Address fields of the current fetch.
    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [c_tag_bits-1:0] w_tag;
    logic                  w_unused;

    assign w_offset = bus.inst_addr[3:2];
    assign w_index  = bus.inst_addr[INDEX_BITS+3:4];
    assign w_tag    = bus.inst_addr[XLEN-1:INDEX_BITS+4];
    assign w_unused = ^bus.inst_addr[1:0];

    // Line storage; data/tag arrays carry no reset, only the valid bits do.
    logic [c_lines-1:0]    r_valid;
    logic [c_tag_bits-1:0] r_tag  [c_lines];
    logic [XLEN-1:0]       r_data [c_lines][4];
    logic [XLEN-1:0]       r_buf  [4];

    // Fill bookkeeping. The fill tag/index live in the upper bits of
    // r_mem_addr, which is loaded at miss time and only its word field moves.
    logic [XLEN-1:0]       r_mem_addr;
    logic [1:0]            r_w;
    logic [c_lat_w-1:0]    r_lat;
    logic [15:0]           r_miss_count;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [c_tag_bits-1:0] w_fill_tag;

    assign w_fill_index = r_mem_addr[INDEX_BITS+3:4];
    assign w_fill_tag   = r_mem_addr[XLEN-1:INDEX_BITS+4];

    logic w_hit;
    logic w_start;
    logic w_capture;
    logic w_last;
    logic w_abort;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_hit        = 1'b0;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_last       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag) && !bus.invalidate;
                if (!bus.invalidate && !w_hit) begin
                    w_start      = 1'b1;
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (bus.invalidate) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_lat == c_lat_last) begin
                    w_capture = 1'b1;
                    if (r_w == 2'd3) begin
                        w_last       = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_valid      <= '0;
            r_mem_addr   <= '0;
            r_w          <= '0;
            r_lat        <= '0;
            r_miss_count <= '0;
        end else begin
            if (bus.invalidate) begin
                r_valid <= '0;
            end else if (w_last) begin
                r_valid[w_fill_index] <= 1'b1;
            end

            if (w_start) begin
                r_mem_addr <= {w_tag, w_index, 4'b0000};
                r_w        <= '0;
                r_lat      <= '0;
                if (r_miss_count != 16'hFFFF) begin
                    r_miss_count <= r_miss_count + 16'd1;
                end
            end else if (w_abort) begin
                r_w   <= '0;
                r_lat <= '0;
            end else if (w_capture) begin
                r_w   <= r_w + 2'd1;
                r_lat <= '0;
                // After the last word the address is left on word 3.
                if (!w_last) begin
                    r_mem_addr[3:2] <= r_w + 2'd1;
                end
            end else if (r_state == S_FILL) begin
                r_lat <= r_lat + c_lat_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer and line write; the final word goes straight from memory.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf[r_w] <= bus.mem_inst;
        end
        if (w_last) begin
            r_tag[w_fill_index]     <= w_fill_tag;
            r_data[w_fill_index][0] <= r_buf[0];
            r_data[w_fill_index][1] <= r_buf[1];
            r_data[w_fill_index][2] <= r_buf[2];
            r_data[w_fill_index][3] <= bus.mem_inst;
        end
    end

    assign bus.hit        = w_hit;
    assign bus.inst       = r_data[w_index][w_offset];
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_rd_en  = (r_state == S_FILL);
    assign bus.miss_count = r_miss_count;

endmodule
`default_nettype wire
